// File: rtl/udma_i2c_cfg_sequencer.sv
// udma_i2c_cfg_sequencer
//   Cfg-bus master that programs one complete I2C uDMA transfer (rx/tx/cmd
//   channels) into the I2C register interface, polls for completion, reads
//   STATUS once and reports the outcome.
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   start_i, abort_i         sequence start (idle only) / abort (non-idle)
//   desc_*_i                 descriptor: cmd/rx/tx start address and size
//   busy_o, done_o           sequence in progress / one-cycle end pulse
//   ack_o, al_o, err_o       STATUS bit2, bit1, error code (0 ok, 1 timeout,
//                            2 abort, 3 bad descriptor)
//   cfg_*                    valid/ready register access port to the I2C
//                            register interface (rwn=1 read)
module udma_i2c_cfg_sequencer #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_GAP       = 8,
  parameter int POLL_MAX       = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [L2_AWIDTH_NOAL-1:0] desc_cmd_saddr_i,
  input  logic [TRANS_SIZE-1:0]     desc_cmd_size_i,
  input  logic [L2_AWIDTH_NOAL-1:0] desc_rx_saddr_i,
  input  logic [TRANS_SIZE-1:0]     desc_rx_size_i,
  input  logic [L2_AWIDTH_NOAL-1:0] desc_tx_saddr_i,
  input  logic [TRANS_SIZE-1:0]     desc_tx_size_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ack_o,
  output logic                      al_o,
  output logic [1:0]                err_o,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i
);
  localparam logic [4:0] REG_RX_SADDR  = 5'h00, REG_RX_SIZE  = 5'h01, REG_RX_CFG  = 5'h02;
  localparam logic [4:0] REG_TX_SADDR  = 5'h04, REG_TX_SIZE  = 5'h05, REG_TX_CFG  = 5'h06;
  localparam logic [4:0] REG_CMD_SADDR = 5'h08, REG_CMD_SIZE = 5'h09, REG_CMD_CFG = 5'h0A;
  localparam logic [4:0] REG_STATUS    = 5'h0C, REG_SETUP    = 5'h0D;
  localparam logic [31:0] CFG_EN = 32'h10;

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_GAP, S_POLL_CMD, S_POLL_RX, S_RD_STATUS, S_RST1, S_RST0, S_DONE
  } state_e;

  typedef struct packed {
    logic [L2_AWIDTH_NOAL-1:0] cmd_saddr;
    logic [TRANS_SIZE-1:0]     cmd_size;
    logic [L2_AWIDTH_NOAL-1:0] rx_saddr;
    logic [TRANS_SIZE-1:0]     rx_size;
    logic [L2_AWIDTH_NOAL-1:0] tx_saddr;
    logic [TRANS_SIZE-1:0]     tx_size;
  } desc_t;

  state_e          state_q, state_d;
  desc_t           desc_q, desc_d;
  logic [3:0]      wr_idx_q, wr_idx_d;     // write slot 0..8: rx(0-2) tx(3-5) cmd(6-8)
  logic [PCW-1:0]  poll_q, poll_d;
  logic [GCW-1:0]  gap_q, gap_d;
  logic            abort_q, abort_d;       // abort seen while an access was stalled
  logic            ack_q, ack_d, al_q, al_d;
  logic [1:0]      err_q, err_d;

  logic            rx_on, tx_on, abort_hit, poll_busy;
  logic [4:0]      slot_addr;
  logic [31:0]     slot_data;
  logic [3:0]      slot_next;
  logic            unused_cfg_data;

  assign rx_on     = |desc_q.rx_size;
  assign tx_on     = |desc_q.tx_size;
  assign abort_hit = abort_q | abort_i;
  assign poll_busy = cfg_data_i[4] | cfg_data_i[5];
  assign unused_cfg_data = ^{cfg_data_i[31:6], cfg_data_i[3], cfg_data_i[0]};

  always_comb begin
    slot_addr = 5'h00;
    slot_data = 32'h0;
    unique case (wr_idx_q)
      4'd0: begin slot_addr = REG_RX_SADDR;  slot_data = 32'(desc_q.rx_saddr);  end
      4'd1: begin slot_addr = REG_RX_SIZE;   slot_data = 32'(desc_q.rx_size);   end
      4'd2: begin slot_addr = REG_RX_CFG;    slot_data = CFG_EN;                end
      4'd3: begin slot_addr = REG_TX_SADDR;  slot_data = 32'(desc_q.tx_saddr);  end
      4'd4: begin slot_addr = REG_TX_SIZE;   slot_data = 32'(desc_q.tx_size);   end
      4'd5: begin slot_addr = REG_TX_CFG;    slot_data = CFG_EN;                end
      4'd6: begin slot_addr = REG_CMD_SADDR; slot_data = 32'(desc_q.cmd_saddr); end
      4'd7: begin slot_addr = REG_CMD_SIZE;  slot_data = 32'(desc_q.cmd_size);  end
      4'd8: begin slot_addr = REG_CMD_CFG;   slot_data = CFG_EN;                end
      default: ;
    endcase
    // After the rx group, skip the tx group when tx is not programmed.
    slot_next = (wr_idx_q == 4'd2 && !tx_on) ? 4'd6 : 4'(wr_idx_q + 4'd1);
  end

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    wr_idx_d = wr_idx_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    abort_d  = abort_q;
    ack_d    = ack_q;
    al_d     = al_q;
    err_d    = err_q;
    cfg_valid_o = 1'b0;
    cfg_rwn_o   = 1'b0;
    cfg_addr_o  = 5'h00;
    cfg_data_o  = 32'h0;

    unique case (state_q)
      S_IDLE: if (start_i) begin
        desc_d  = '{desc_cmd_saddr_i, desc_cmd_size_i, desc_rx_saddr_i,
                    desc_rx_size_i, desc_tx_saddr_i, desc_tx_size_i};
        ack_d   = 1'b0;
        al_d    = 1'b0;
        err_d   = 2'd0;
        poll_d  = '0;
        abort_d = 1'b0;
        wr_idx_d = (|desc_rx_size_i) ? 4'd0 : (|desc_tx_size_i) ? 4'd3 : 4'd6;
        if (desc_cmd_size_i == '0) begin
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = slot_addr;
        cfg_data_o  = slot_data;
        if (abort_i) abort_d = 1'b1;
        if (cfg_ready_i) begin
          if (abort_hit) begin
            err_d = 2'd2; state_d = S_RST1;
          end else if (wr_idx_q == 4'd8) begin
            gap_d = '0; state_d = S_GAP;
          end else begin
            wr_idx_d = slot_next;
          end
        end
      end
      S_GAP: begin
        if (abort_hit) begin
          err_d = 2'd2; state_d = S_RST1;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_POLL_CMD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_POLL_CMD, S_POLL_RX: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = (state_q == S_POLL_CMD) ? REG_CMD_CFG : REG_RX_CFG;
        if (abort_i) abort_d = 1'b1;
        if (cfg_ready_i) begin
          // Abort outranks a timeout that lands in the same cycle.
          if (abort_hit) begin
            err_d = 2'd2; state_d = S_RST1;
          end else if (poll_busy) begin
            if (poll_q == POLL_LAST) begin
              err_d = 2'd1; state_d = S_RST1;
            end else begin
              poll_d = poll_q + 1'b1;
              gap_d  = '0;
              state_d = S_GAP;
            end
          end else if (state_q == S_POLL_CMD && rx_on) begin
            state_d = S_POLL_RX;
          end else begin
            state_d = S_RD_STATUS;
          end
        end
      end
      S_RD_STATUS: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = REG_STATUS;
        if (abort_i) abort_d = 1'b1;
        if (cfg_ready_i) begin
          ack_d = cfg_data_i[2];
          al_d  = cfg_data_i[1];
          if (abort_hit) begin
            err_d = 2'd2; state_d = S_RST1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RST1: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_SETUP;
        cfg_data_o  = 32'h1;
        if (cfg_ready_i) state_d = S_RST0;
      end
      S_RST0: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_SETUP;
        cfg_data_o  = 32'h0;
        if (cfg_ready_i) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      desc_q   <= '0;
      wr_idx_q <= '0;
      poll_q   <= '0;
      gap_q    <= '0;
      abort_q  <= 1'b0;
      ack_q    <= 1'b0;
      al_q     <= 1'b0;
      err_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      wr_idx_q <= wr_idx_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      abort_q  <= abort_d;
      ack_q    <= ack_d;
      al_q     <= al_d;
      err_q    <= err_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign ack_o  = ack_q;
  assign al_o   = al_q;
  assign err_o  = err_q;
endmodule

// File: tb/tb_udma_i2c_cfg_sequencer.sv
// Bench for udma_i2c_cfg_sequencer: directed plan scenarios plus randomized
// descriptors/poll scripts, checked against a transaction-list reference model.
module tb_udma_i2c_cfg_sequencer;
  localparam int G  = 3;  // poll gap
  localparam int PM = 4;  // polls before timeout

  localparam logic [4:0] A_RXS = 5'h00, A_RXZ = 5'h01, A_RXC = 5'h02;
  localparam logic [4:0] A_TXS = 5'h04, A_TXZ = 5'h05, A_TXC = 5'h06;
  localparam logic [4:0] A_CMS = 5'h08, A_CMZ = 5'h09, A_CMC = 5'h0A;
  localparam logic [4:0] A_ST  = 5'h0C, A_SET = 5'h0D;

  logic clk = 1'b0, rstn_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic [11:0] desc_cmd_saddr_i = '0, desc_rx_saddr_i = '0, desc_tx_saddr_i = '0;
  logic [15:0] desc_cmd_size_i = '0, desc_rx_size_i = '0, desc_tx_size_i = '0;
  logic busy_o, done_o, ack_o, al_o, cfg_valid_o, cfg_rwn_o;
  logic [1:0] err_o;
  logic [31:0] cfg_data_o, cfg_data_i = '0;
  logic [4:0] cfg_addr_o;
  logic cfg_ready_i = 1'b1;

  udma_i2c_cfg_sequencer #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_GAP(G), .POLL_MAX(PM)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .desc_cmd_saddr_i(desc_cmd_saddr_i), .desc_cmd_size_i(desc_cmd_size_i),
    .desc_rx_saddr_i(desc_rx_saddr_i), .desc_rx_size_i(desc_rx_size_i),
    .desc_tx_saddr_i(desc_tx_saddr_i), .desc_tx_size_i(desc_tx_size_i),
    .busy_o(busy_o), .done_o(done_o), .ack_o(ack_o), .al_o(al_o), .err_o(err_o),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o),
    .cfg_rwn_o(cfg_rwn_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // scenario
  logic [11:0] d_cms, d_rxs, d_txs;
  logic [15:0] d_cmz, d_rxz, d_txz;
  int n_cmd_busy, n_rx_busy, stall_at, stall_len, abort_at, start_busy_at, rst_after;
  logic [31:0] busy_val, status_val;
  // responder / observation
  int cmd_r, rx_r, stalled, cyc, n_done;
  typedef struct { logic [37:0] v; int cyc; } acc_t;
  acc_t obs_q[$];
  logic [37:0] exp_q[$];
  int exp_dl[$];
  logic e_ack, e_al;
  logic [1:0] e_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [4:0] a, input logic r, input logic [31:0] d, input int dl);
    exp_q.push_back({a, r, r ? 32'h0 : d});
    exp_dl.push_back(exp_q.size() == 1 ? 0 : dl);
  endfunction

  // Reference: the full ordered list of cfg accesses, the cycle distance to the
  // previous access (ready always high), and the final result.
  function automatic void build_exp();
    int polls, c, r, dl;
    logic busy, tmo;
    exp_q.delete(); exp_dl.delete();
    e_ack = 1'b0; e_al = 1'b0; e_err = 2'd0;
    if (d_cmz == 0) begin e_err = 2'd3; return; end
    if (d_rxz != 0) begin push(A_RXS, 0, 32'(d_rxs), 1); push(A_RXZ, 0, 32'(d_rxz), 1); push(A_RXC, 0, 32'h10, 1); end
    if (d_txz != 0) begin push(A_TXS, 0, 32'(d_txs), 1); push(A_TXZ, 0, 32'(d_txz), 1); push(A_TXC, 0, 32'h10, 1); end
    push(A_CMS, 0, 32'(d_cms), 1); push(A_CMZ, 0, 32'(d_cmz), 1); push(A_CMC, 0, 32'h10, 1);
    if (abort_at >= 0 && abort_at < exp_q.size()) begin
      while (exp_q.size() > abort_at + 1) begin void'(exp_q.pop_back()); void'(exp_dl.pop_back()); end
      push(A_SET, 0, 32'h1, 1); push(A_SET, 0, 32'h0, 1);
      e_err = 2'd2;
      return;
    end
    polls = 0; c = 0; r = 0; dl = G + 1; tmo = 1'b0;
    for (int guard = 0; guard < 64; guard++) begin
      push(A_CMC, 1, 0, dl);
      busy = (c < n_cmd_busy); c++;
      if (!busy && d_rxz != 0) begin
        push(A_RXC, 1, 0, 1);
        busy = (r < n_rx_busy); r++;
      end
      if (!busy) break;
      polls++;
      dl = G + 1;
      if (polls == PM) begin tmo = 1'b1; break; end
    end
    if (tmo) begin
      push(A_SET, 0, 32'h1, 1); push(A_SET, 0, 32'h0, 1);
      e_err = 2'd1;
    end else begin
      push(A_ST, 1, 0, 1);
      e_ack = status_val[2]; e_al = status_val[1];
    end
  endfunction

  // One clock of the cfg slave, acting at the falling edge.
  task automatic step();
    logic [37:0] v;
    @(negedge clk);
    cyc++;
    start_i = 1'b0; abort_i = 1'b0; cfg_ready_i = 1'b1; cfg_data_i = $urandom & 32'hFFFF_FFCF;
    if (done_o) n_done++;
    if (cyc == start_busy_at) begin
      start_i = 1'b1;
      desc_cmd_saddr_i = 12'($urandom); desc_cmd_size_i = 16'($urandom);
      desc_rx_saddr_i  = 12'($urandom); desc_rx_size_i  = 16'($urandom);
      desc_tx_saddr_i  = 12'($urandom); desc_tx_size_i  = 16'($urandom);
    end
    if (cfg_valid_o) begin
      v = {cfg_addr_o, cfg_rwn_o, cfg_rwn_o ? 32'h0 : cfg_data_o};
      if (obs_q.size() == stall_at && stalled < stall_len) begin
        if (obs_q.size() < exp_q.size()) chk("stall_hold", v, exp_q[obs_q.size()]);
        cfg_ready_i = 1'b0;
        if (stalled == 0 && abort_at == stall_at) abort_i = 1'b1;
        stalled++;
      end else begin
        obs_q.push_back('{v, cyc});
        if (cfg_rwn_o) begin
          if (cfg_addr_o == A_CMC) begin
            if (cmd_r < n_cmd_busy) cfg_data_i = busy_val;
            cmd_r++;
          end else if (cfg_addr_o == A_RXC) begin
            if (rx_r < n_rx_busy) cfg_data_i = busy_val;
            rx_r++;
          end else if (cfg_addr_o == A_ST) begin
            cfg_data_i = status_val;
          end
        end
      end
    end
  endtask

  task automatic run_seq(input string nm);
    int n;
    build_exp();
    obs_q.delete();
    cmd_r = 0; rx_r = 0; stalled = 0; n_done = 0;
    @(negedge clk);
    desc_cmd_saddr_i = d_cms; desc_cmd_size_i = d_cmz;
    desc_rx_saddr_i  = d_rxs; desc_rx_size_i  = d_rxz;
    desc_tx_saddr_i  = d_txs; desc_tx_size_i  = d_txz;
    start_i = 1'b1; cyc = 0;
    while (n_done == 0 && cyc < 400) begin
      step();
      if (cyc == 1) chk({nm, "_busy"}, busy_o, 1);
      if (rst_after >= 0 && obs_q.size() >= rst_after) begin
        #2 rstn_i = 1'b0;
        #1 chk({nm, "_async_rst"}, {busy_o, done_o, ack_o, al_o, err_o, cfg_valid_o,
                                    cfg_rwn_o, cfg_addr_o, cfg_data_o}, 0);
        @(negedge clk); rstn_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        return;
      end
    end
    chk({nm, "_done_seen"}, n_done, 1);
    chk({nm, "_result"}, {ack_o, al_o, err_o}, {e_ack, e_al, e_err});
    step();
    chk({nm, "_after_done"}, {n_done[7:0], busy_o, done_o, ack_o, al_o, err_o},
        {8'd1, 1'b0, 1'b0, e_ack, e_al, e_err});
    chk({nm, "_n_acc"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_acc%0d", nm, i), obs_q[i].v, exp_q[i]);
      if (stall_len == 0 && i > 0)
        chk($sformatf("%s_dly%0d", nm, i), obs_q[i].cyc - obs_q[i-1].cyc, exp_dl[i]);
    end
  endtask

  task automatic base(input logic [11:0] cs, input logic [15:0] cz, input logic [11:0] rs,
                      input logic [15:0] rz, input logic [11:0] ts, input logic [15:0] tz);
    d_cms = cs; d_cmz = cz; d_rxs = rs; d_rxz = rz; d_txs = ts; d_txz = tz;
    n_cmd_busy = 0; n_rx_busy = 0; busy_val = 32'h10; status_val = 32'h0;
    stall_at = -1; stall_len = 0; abort_at = -1; start_busy_at = -1; rst_after = -1;
  endtask

  initial begin
    #3 rstn_i = 1'b0;
    #1 chk("reset_outs", {busy_o, done_o, ack_o, al_o, err_o, cfg_valid_o, cfg_rwn_o,
                          cfg_addr_o, cfg_data_o}, 0);
    #20 rstn_i = 1'b1;

    // 1: full sequence, 3 busy cmd polls
    base(12'h100, 16'd8, 12'h200, 16'd4, 12'h300, 16'd2);
    n_cmd_busy = 3; status_val = 32'h4;
    run_seq("t1");
    // 2: cmd only, arbitration lost
    base(12'h040, 16'd3, 12'h000, 16'd0, 12'h000, 16'd0);
    status_val = 32'h2;
    run_seq("t2");
    // 3: 2nd write stalled 5 cycles
    base(12'h100, 16'd8, 12'h200, 16'd4, 12'h300, 16'd2);
    stall_at = 1; stall_len = 5; status_val = 32'h4;
    run_seq("t3");
    // 4: cmd never completes -> timeout
    base(12'h100, 16'd8, 12'h200, 16'd4, 12'h300, 16'd2);
    n_cmd_busy = 100; busy_val = 32'h20;
    run_seq("t4");
    // 5: abort on stalled 3rd write, plus start while busy
    base(12'h100, 16'd8, 12'h200, 16'd4, 12'h300, 16'd2);
    stall_at = 2; stall_len = 2; abort_at = 2; start_busy_at = 4;
    run_seq("t5");
    base(12'h123, 16'd0, 12'h200, 16'd4, 12'h300, 16'd2);
    run_seq("t5_bad");
    // 6: reset mid-poll, then a clean sequence
    base(12'h100, 16'd8, 12'h200, 16'd4, 12'h300, 16'd2);
    n_cmd_busy = 3; rst_after = 11;
    run_seq("t6_rst");
    base(12'h100, 16'd8, 12'h200, 16'd4, 12'h300, 16'd2);
    n_cmd_busy = 1; status_val = 32'h6;
    run_seq("t6_clean");

    // randomized descriptors, poll scripts, stalls
    for (int it = 0; it < 16; it++) begin
      base(12'($urandom), 16'($urandom_range(1, 65535)), 12'($urandom),
           ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
           12'($urandom),
           ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
      n_cmd_busy = $urandom_range(0, 5);
      n_rx_busy  = $urandom_range(0, 2);
      busy_val   = ($urandom & 32'hFFFF_FFCF) | (32'($urandom_range(1, 3)) << 4);
      status_val = $urandom;
      start_busy_at = 3;
      if ($urandom_range(0, 1) == 1) begin
        stall_at = $urandom_range(0, 2); stall_len = $urandom_range(1, 4);
      end
      run_seq($sformatf("r%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
